// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader and the CPU fetch path.
// Both sides take the instruction RAM base and reset vector from here.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [1:0]  LAST_BYTE      = 2'(BYTES_PER_WORD - 1);
  localparam logic [31:0] IMEM_BASE      = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR   = IMEM_BASE;

  // Big-endian packing: earlier bytes migrate toward bit 31.
  function automatic logic [31:0] pack_be(input logic [31:0] acc, input logic [7:0] b);
    return {acc[23:0], b};
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; word_valid strobes
// combinationally alongside the 4th byte of each group.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_r;
  logic [31:0] shreg_r;

  // Byte counter and shift register; clear discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= 2'd0;
      shreg_r <= 32'd0;
    end else if (clear) begin
      cnt_r   <= 2'd0;
      shreg_r <= 32'd0;
    end else if (in_valid) begin
      cnt_r   <= cnt_r + 2'd1;
      shreg_r <= pack_be(shreg_r, in_data);
    end
  end

  assign word_valid = in_valid && !clear && (cnt_r == LAST_BYTE);
  assign word       = pack_be(shreg_r, in_data);

endmodule

// File: rtl/prog_loader.sv
// UART program loader: holds the CPU while a length-prefixed image is written
// into instruction RAM, and owns the RAM address/write port mux.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH_LOG2     = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit BOOT_WAIT      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  load_req,
  input  logic [31:0]           cpu_addr,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  error,
  output logic [DEPTH_LOG2:0]   words_loaded
);

  localparam int                  TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]    TMO_ONE     = TMO_W'(1);
  localparam logic [DEPTH_LOG2:0] CNT_ONE     = (DEPTH_LOG2 + 1)'(1);
  localparam logic [31:0]         DEPTH_WORDS = 32'd1 << DEPTH_LOG2;
  localparam state_t              RESET_STATE = BOOT_WAIT ? ST_HDR : ST_RUN;

  state_t                state_r, state_next;
  logic                  cpu_hold_r, busy_r, error_r, mem_we_r, started_r;
  logic [31:0]           mem_wdata_r;
  logic [DEPTH_LOG2-1:0] load_addr_r, widx_r;
  logic [DEPTH_LOG2:0]   count_r, words_loaded_r;
  logic [TMO_W-1:0]      tmo_r;

  logic        loading_s, accept_s, timeout_s, word_valid_s, hdr_ok_s, last_word_s;
  logic        write_s, hdr_take_s;
  logic [31:0] word_s;
  logic        unused_addr_bits;

  assign loading_s   = (state_r == ST_HDR) || (state_r == ST_DATA);
  assign accept_s    = rx_valid && !load_req && loading_s;
  assign timeout_s   = started_r && loading_s && !rx_valid && !load_req && (tmo_r == TMO_LAST);
  assign hdr_ok_s    = (word_s != 32'd0) && (word_s <= DEPTH_WORDS);
  assign last_word_s = (words_loaded_r + CNT_ONE) == count_r;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_req || timeout_s),
    .in_valid   (accept_s),
    .in_data    (rx_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Next-state decode plus the one-cycle write/header-capture strobes.
  always_comb begin
    state_next = state_r;
    write_s    = 1'b0;
    hdr_take_s = 1'b0;
    if (load_req) begin
      state_next = ST_HDR;
    end else begin
      case (state_r)
        ST_HDR: begin
          if (timeout_s) begin
            state_next = ST_ERR;
          end else if (word_valid_s) begin
            hdr_take_s = hdr_ok_s;
            state_next = hdr_ok_s ? ST_DATA : ST_ERR;
          end else begin
            state_next = ST_HDR;
          end
        end
        ST_DATA: begin
          if (timeout_s) begin
            state_next = ST_ERR;
          end else if (word_valid_s) begin
            write_s    = 1'b1;
            state_next = last_word_s ? ST_RUN : ST_DATA;
          end else begin
            state_next = ST_DATA;
          end
        end
        ST_RUN:  state_next = ST_RUN;
        ST_ERR:  state_next = ST_ERR;
        default: state_next = ST_ERR;
      endcase
    end
  end

  // State, status flags, write port and load bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= RESET_STATE;
      cpu_hold_r     <= BOOT_WAIT;
      busy_r         <= BOOT_WAIT;
      error_r        <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_wdata_r    <= 32'd0;
      load_addr_r    <= '0;
      widx_r         <= '0;
      count_r        <= '0;
      words_loaded_r <= '0;
      tmo_r          <= '0;
      started_r      <= 1'b0;
    end else begin
      state_r    <= state_next;
      // Hold stays up through the cycle of the final write pulse.
      cpu_hold_r <= (state_next != ST_RUN) || (state_r != ST_RUN);
      busy_r     <= (state_next == ST_HDR) || (state_next == ST_DATA);
      error_r    <= (state_next == ST_ERR);
      mem_we_r   <= write_s;
      if (write_s) begin
        mem_wdata_r <= word_s;
        load_addr_r <= widx_r;
      end
      if (load_req) begin
        widx_r         <= '0;
        words_loaded_r <= '0;
        tmo_r          <= '0;
        started_r      <= 1'b0;
      end else begin
        if (hdr_take_s) begin
          count_r <= word_s[DEPTH_LOG2:0];
          widx_r  <= '0;
        end else if (write_s) begin
          widx_r         <= widx_r + DEPTH_LOG2'(1);
          words_loaded_r <= words_loaded_r + CNT_ONE;
        end
        if (timeout_s) begin
          tmo_r     <= '0;
          started_r <= 1'b0;
        end else if (accept_s) begin
          tmo_r     <= '0;
          started_r <= 1'b1;
        end else if (started_r && loading_s) begin
          tmo_r <= tmo_r + TMO_ONE;
        end
      end
    end
  end

  assign unused_addr_bits = ^{cpu_addr[31:DEPTH_LOG2+2], cpu_addr[1:0]};

  assign mem_addr     = cpu_hold_r ? load_addr_r : cpu_addr[DEPTH_LOG2+1:2];
  assign mem_we       = mem_we_r && cpu_hold_r;
  assign mem_wdata    = mem_wdata_r;
  assign cpu_hold     = cpu_hold_r;
  assign busy         = busy_r;
  assign error        = error_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (DEPTH_LOG2=8, TIMEOUT_CYCLES=16).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        load_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_hold, busy, error;
  logic [8:0]  words_loaded;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  prog_loader #(.DEPTH_LOG2(8), .TIMEOUT_CYCLES(16), .BOOT_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .load_req(load_req), .cpu_addr(cpu_addr), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge after the rising edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  int we_before;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_hold2", {31'd0, cpu_hold}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);
    check("rst_words", {23'd0, words_loaded}, 32'd0);

    // Two-word load
    send_word(32'h0000_0002);
    check("hdr_busy", {31'd0, busy}, 32'd1);
    send_word(32'h2008_0040);
    check("w0_we", {31'd0, mem_we}, 32'd1);
    check("w0_addr", {24'd0, mem_addr}, 32'd0);
    check("w0_data", mem_wdata, 32'h2008_0040);
    send_word(32'hAC08_0000);
    check("w1_we", {31'd0, mem_we}, 32'd1);
    check("w1_addr", {24'd0, mem_addr}, 32'd1);
    check("w1_data", mem_wdata, 32'hAC08_0000);
    check("w1_hold", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    check("rel_hold", {31'd0, cpu_hold}, 32'd0);
    check("rel_we", {31'd0, mem_we}, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);
    check("rel_words", {23'd0, words_loaded}, 32'd2);
    cpu_addr = 32'h0000_0123;
    #1 check("mux_a", {24'd0, mem_addr}, 32'h48);
    cpu_addr = 32'hFFFF_F3FC;
    #1 check("mux_b", {24'd0, mem_addr}, 32'hFF);

    // Bytes in RUN are ignored
    we_before = we_cnt;
    send_word(32'h1234_5678);
    check("run_ign_we", we_cnt, we_before);
    check("run_ign_words", {23'd0, words_loaded}, 32'd2);
    check("run_ign_hold", {31'd0, cpu_hold}, 32'd0);

    // Oversized header -> ERR; bytes ignored; load_req recovers
    pulse_load_req();
    check("lr_hold", {31'd0, cpu_hold}, 32'd1);
    check("lr_busy", {31'd0, busy}, 32'd1);
    check("lr_words", {23'd0, words_loaded}, 32'd0);
    we_before = we_cnt;
    send_word(32'h0000_0101);
    check("big_err", {31'd0, error}, 32'd1);
    check("big_hold", {31'd0, cpu_hold}, 32'd1);
    check("big_busy", {31'd0, busy}, 32'd0);
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    check("err_no_we", we_cnt, we_before);
    check("err_sticky", {31'd0, error}, 32'd1);
    pulse_load_req();
    check("clr_err", {31'd0, error}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);

    // Zero-length header is an error; N = 256 is accepted
    send_word(32'h0000_0000);
    check("zero_err", {31'd0, error}, 32'd1);
    pulse_load_req();
    send_word(32'h0000_0100);
    check("max_err", {31'd0, error}, 32'd0);
    check("max_busy", {31'd0, busy}, 32'd1);

    // Timeout with a partial word pending
    pulse_load_req();
    we_before = we_cnt;
    send_word(32'h0000_0001);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (15) @(negedge clk);
    check("tmo_early", {31'd0, error}, 32'd0);
    @(negedge clk);
    check("tmo_err", {31'd0, error}, 32'd1);
    check("tmo_hold", {31'd0, cpu_hold}, 32'd1);
    check("tmo_no_we", we_cnt, we_before);

    // load_req collides with a mid-word byte: byte dropped, packer reset
    pulse_load_req();
    send_word(32'h0000_0002);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hCC;
    load_req = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    load_req = 1'b0;
    check("col_busy", {31'd0, busy}, 32'd1);
    check("col_err", {31'd0, error}, 32'd0);
    check("col_words", {23'd0, words_loaded}, 32'd0);
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
    check("col_we", {31'd0, mem_we}, 32'd1);
    check("col_addr", {24'd0, mem_addr}, 32'd0);
    check("col_data", mem_wdata, 32'h0102_0304);
    @(negedge clk);
    check("col_rel", {31'd0, cpu_hold}, 32'd0);

    // Reset mid-load, then a clean one-word load
    pulse_load_req();
    send_word(32'h0000_0003);
    send_word(32'h0A0B_0C0D);
    send_byte(8'h55);
    check("mid_words", {23'd0, words_loaded}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr_hold", {31'd0, cpu_hold}, 32'd1);
    check("mr_busy", {31'd0, busy}, 32'd1);
    check("mr_words", {23'd0, words_loaded}, 32'd0);
    check("mr_we", {31'd0, mem_we}, 32'd0);
    check("mr_err", {31'd0, error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_word(32'h0000_0001);
    send_word(32'h0800_0003);
    check("post_we", {31'd0, mem_we}, 32'd1);
    check("post_addr", {24'd0, mem_addr}, 32'd0);
    check("post_data", mem_wdata, 32'h0800_0003);
    @(negedge clk);
    check("post_hold", {31'd0, cpu_hold}, 32'd0);
    check("post_words", {23'd0, words_loaded}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
